div_iter: RTL and testbench
===========================

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operands and sign presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port sign  input  1  0 unsigned, 1 signed two's complement.
REQ-007 SHALL have port dividend  input  WIDTH  numerator.
REQ-008 SHALL have port divisor  input  WIDTH  denominator.
REQ-009 SHALL have port out_valid  output  1  result held stable.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port quotient  output  WIDTH  quotient (MIPS LO).
REQ-012 SHALL have port remainder  output  WIDTH  remainder (MIPS HI).
REQ-013 SHALL have port div_zero  output  1  result came from zero divisor.
REQ-014 SHALL have port busy  output  1  operation accepted and result not yet consumed.

Function
REQ-015 SHALL implement FSM IDLE, CALC, FIX, DONE; in_ready = (state==IDLE); busy = (state!=IDLE).
REQ-016 SHALL accept on in_valid && in_ready, registering sign, operands, and the absolute values when sign=1.
REQ-017 SHALL go IDLE->CALC on accept with nonzero divisor; IDLE->DONE on accept with zero divisor.
REQ-018 SHALL perform one restoring shift-subtract step per cycle in CALC, exactly WIDTH cycles, counter width $clog2(WIDTH+1).
REQ-019 SHALL go CALC->FIX after the last step; in FIX, negate quotient if operand signs differ and negate remainder if dividend negative (signed only); FIX->DONE.
REQ-020 SHALL make nonzero-divisor latency from accept edge to out_valid high exactly WIDTH+2 cycles; zero-divisor latency 1 cycle.
REQ-021 SHALL give zero divisor results quotient = all ones, remainder = dividend unchanged, div_zero=1, both modes.
REQ-022 SHALL give signed most-negative / -1 results quotient = most-negative, remainder = 0, div_zero=0.
REQ-023 SHALL hold out_valid=1 and quotient/remainder/div_zero stable in DONE until out_ready; DONE->IDLE on out_valid && out_ready.
REQ-024 SHALL ignore in_valid while not in IDLE; a new accept is possible the cycle after the DONE->IDLE handshake (no same-cycle bypass).
REQ-025 SHALL drive out_valid=0 outside DONE; quotient/remainder keep their last value outside DONE.

Reset
REQ-026 SHALL on rst, at any time including mid-CALC, force state IDLE, counter 0, quotient 0, remainder 0, div_zero 0, out_valid 0, busy 0, in_ready 1 after release.
REQ-027 SHALL not emit any partial result after a mid-operation reset.

Configuration
REQ-028 SHALL, when macro DIV_CANCEL_EN is defined, add port cancel  input  1  pipeline flush, forcing any state to IDLE next edge with no result, and taking priority over out_ready and accept in that cycle.
REQ-029 SHALL, without DIV_CANCEL_EN, omit the cancel port; an operation then always completes.

Structure
REQ-030 SHALL place the FSM state enum and default-width constant DIV_WIDTH_DEF=32 in shared package div_pkg.
REQ-031 SHALL factor one combinational restoring step (partial remainder, divisor in; next remainder, quotient bit out) into sub-module div_step.

Verification
REQ-032 SHALL cover unsigned 100/7, WIDTH=32 -> quotient 14, remainder 2, div_zero 0, out_valid exactly 34 cycles after accept.
REQ-033 SHALL cover signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-034 SHALL cover 5/0, either sign -> out_valid 1 cycle after accept, quotient 0xFFFFFFFF, remainder 5, div_zero 1.
REQ-035 SHALL cover out_ready held low 10 cycles in DONE -> outputs stable and in_ready 0 throughout; in_valid pulses ignored.
REQ-036 SHALL cover rst asserted at CALC cycle 10 -> outputs at reset values, no out_valid afterwards; next op 9/3 -> quotient 3, remainder 0.
REQ-037 SHALL cover, with DIV_CANCEL_EN, cancel at CALC cycle 5 -> IDLE next edge, no out_valid, in_ready 1; and a WIDTH=8 run of 0xFF/0x10 unsigned -> quotient 0x0F, remainder 0x0F, latency 10.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step: shift in the next dividend
// bit, subtract the divisor if it fits, emit the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor, so the shifted value fits WIDTH+1 bits and a set top
  // bit of the difference means the divisor did not fit.
  assign shifted = {rem_in, bit_in};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider, one quotient bit per cycle, MIPS-style
// results. Defining DIV_CANCEL_EN adds a cancel port that flushes any operation.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DIV_CANCEL_EN
  input  logic             cancel,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic             cancel_w;
  logic             accept;
  logic             divisor_zero;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;

`ifdef DIV_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  assign accept       = in_valid && in_ready;
  assign divisor_zero = (divisor == '0);
  assign dvd_neg      = sign && dividend[WIDTH-1];
  assign dvs_neg      = sign && divisor[WIDTH-1];

  // dq_q starts as |dividend| and fills with quotient bits from the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dq_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = divisor_zero ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == LAST_STEP) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cancel_w) state_d = S_IDLE;
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path can infer a latch.
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dq_d        = dq_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    if (cancel_w) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_d     = '0;
            rem_d     = '0;
            dq_d      = dvd_neg ? -dividend : dividend;
            dvs_d     = dvs_neg ? -divisor : divisor;
            neg_quo_d = dvd_neg ^ dvs_neg;
            neg_rem_d = dvd_neg;
            if (divisor_zero) begin
              quotient_d  = '1;
              remainder_d = dividend;
              div_zero_d  = 1'b1;
            end
          end
        end
        S_CALC: begin
          rem_d = step_rem;
          dq_d  = {dq_q[WIDTH-2:0], step_q_bit};
          cnt_d = cnt_q + CW'(1);
        end
        S_FIX: begin
          quotient_d  = neg_quo_q ? -dq_q : dq_q;
          remainder_d = neg_rem_q ? -rem_q : rem_q;
          div_zero_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      dq_q        <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dq_q        <= dq_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: 32-bit and 8-bit instances, directed vectors,
// latency, hold, reset and (with DIV_CANCEL_EN) cancel scenarios.
module tb_div_iter;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef DIV_CANCEL_EN
  logic cancel = 1'b0;
`endif

  logic        in_valid32 = 1'b0, sign32 = 1'b0, out_ready32 = 1'b1;
  logic [31:0] dvd32 = '0, dvs32 = '0;
  logic        in_ready32, out_valid32, div_zero32, busy32;
  logic [31:0] quotient32, remainder32;

  logic        in_valid8 = 1'b0, sign8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0]  dvd8 = '0, dvs8 = '0;
  logic        in_ready8, out_valid8, div_zero8, busy8;
  logic [7:0]  quotient8, remainder8;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb32[$];
  exp_t sb8[$];
  exp_t e32, e8;
  int   edge_cnt = 0;
  int   acc32 = 0, acc8 = 0;
  logic seen32 = 1'b0, seen8 = 1'b0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .rst       (rst),
`ifdef DIV_CANCEL_EN
    .cancel    (cancel),
`endif
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .sign      (sign32),
    .dividend  (dvd32),
    .divisor   (dvs32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .quotient  (quotient32),
    .remainder (remainder32),
    .div_zero  (div_zero32),
    .busy      (busy32)
  );

  div_iter #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
`ifdef DIV_CANCEL_EN
    .cancel    (cancel),
`endif
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .sign      (sign8),
    .dividend  (dvd8),
    .divisor   (dvs8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .quotient  (quotient8),
    .remainder (remainder8),
    .div_zero  (div_zero8),
    .busy      (busy8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Accept edge counts as latency cycle 1.
  always @(posedge clk) begin
    edge_cnt++;
    if (in_valid32 && in_ready32) acc32 = edge_cnt;
    if (in_valid8 && in_ready8) acc8 = edge_cnt;
  end

  always @(negedge clk) begin
    if (rst) begin
      seen32 = 1'b0;
    end else if (out_valid32) begin
      if (!seen32) begin
        seen32 = 1'b1;
        if (sb32.size() == 0) check("spurious_valid32", out_valid32, 1'b0);
        else check("latency32", 64'(edge_cnt - acc32 + 1), 64'(sb32[0].lat));
      end
      if (out_ready32 && sb32.size() > 0) begin
        e32 = sb32.pop_front();
        check("quotient32", quotient32, e32.q);
        check("remainder32", remainder32, e32.r);
        check("div_zero32", div_zero32, e32.dz);
        seen32 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      seen8 = 1'b0;
    end else if (out_valid8) begin
      if (!seen8) begin
        seen8 = 1'b1;
        if (sb8.size() == 0) check("spurious_valid8", out_valid8, 1'b0);
        else check("latency8", 64'(edge_cnt - acc8 + 1), 64'(sb8[0].lat));
      end
      if (out_ready8 && sb8.size() > 0) begin
        e8 = sb8.pop_front();
        check("quotient8", quotient8, e8.q);
        check("remainder8", remainder8, e8.r);
        check("div_zero8", div_zero8, e8.dz);
        seen8 = 1'b0;
      end
    end
  end

  // Drives one accept cycle from a negedge; returns on the following negedge.
  task automatic start(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    while (!(w == 8 ? in_ready8 : in_ready32) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("issue_ready", (w == 8 ? in_ready8 : in_ready32), 1'b1);
    if (w == 8) begin
      sign8 = s; dvd8 = a[7:0]; dvs8 = b[7:0]; in_valid8 = 1'b1;
    end else begin
      sign32 = s; dvd32 = a; dvs32 = b; in_valid32 = 1'b1;
    end
    @(negedge clk);
    in_valid8  = 1'b0;
    in_valid32 = 1'b0;
  endtask

  task automatic issue(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input logic dz, input int lat);
    exp_t e;
    e.q = 64'(q); e.r = 64'(r); e.dz = dz; e.lat = lat;
    if (w == 8) sb8.push_back(e);
    else sb32.push_back(e);
    start(w, s, a, b);
  endtask

  task automatic drain();
    int k = 0;
    while ((sb32.size() != 0 || sb8.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("drain_done", 64'(sb32.size() + sb8.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic watch_quiet(input string name);
    logic seen = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (out_valid32) seen = 1'b1;
    end
    check(name, seen, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_out_valid", out_valid32, 1'b0);
    check("rst_in_ready", in_ready32, 1'b1);
    check("rst_busy", busy32, 1'b0);
    check("rst_quotient", quotient32, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(32, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34);
    drain();
    issue(32, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34);
    drain();
    issue(32, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          1'b0, 34);
    drain();
    issue(32, 1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1);
    drain();
    issue(32, 1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1);
    drain();
    issue(32, 1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1);
    drain();
    issue(32, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'h0,          1'b0, 34);
    drain();
    issue(32, 1'b0, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 34);
    drain();
    issue(32, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34);
    drain();
    issue(32, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  1'b0, 34);
    drain();
    issue(8,  1'b0, 32'hFF,         32'h10,         32'h0F,         32'h0F,         1'b0, 10);
    drain();
    issue(8,  1'b1, 32'h80,         32'hFF,         32'h80,         32'h0,          1'b0, 10);
    drain();

    // Consumer stalls 10 cycles in DONE while new requests are offered.
    out_ready32 = 1'b0;
    issue(32, 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 34);
    for (int k = 0; k < 60 && !out_valid32; k++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", out_valid32, 1'b1);
      check("hold_in_ready", in_ready32, 1'b0);
      check("hold_quotient", quotient32, 32'd3);
      check("hold_remainder", remainder32, 32'd2);
      in_valid32 = i[0];
      dvd32 = 32'd99; dvs32 = 32'd0; sign32 = 1'b0;
      @(negedge clk);
    end
    in_valid32  = 1'b0;
    out_ready32 = 1'b1;
    drain();

    // Reset in the middle of CALC.
    start(32, 1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", busy32, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid32, 1'b0);
    check("mid_rst_busy", busy32, 1'b0);
    check("mid_rst_in_ready", in_ready32, 1'b1);
    check("mid_rst_quotient", quotient32, 32'h0);
    check("mid_rst_remainder", remainder32, 32'h0);
    check("mid_rst_div_zero", div_zero32, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch_quiet("post_rst_quiet");
    issue(32, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);
    drain();

`ifdef DIV_CANCEL_EN
    start(32, 1'b0, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_in_ready", in_ready32, 1'b1);
    check("cancel_out_valid", out_valid32, 1'b0);
    check("cancel_busy", busy32, 1'b0);
    watch_quiet("post_cancel_quiet");
    issue(32, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
